// File: rtl/snn_aer_pkg.sv
// Shared constants, event type and address-width helper for the AER spike encoder.
package snn_aer_pkg;

    localparam int DEF_ACTIVE_PERIOD = 5;
    localparam int DEF_QUIET_PERIOD  = 100;
    localparam int AER_ADDR_MAX_W    = 6;

    typedef struct packed {
        logic [AER_ADDR_MAX_W-1:0] addr;
    } aer_event_t;

    function automatic int aer_addr_w(input int n_pix);
        return (n_pix <= 2) ? 1 : $clog2(n_pix);
    endfunction

endpackage

// File: rtl/aer_sync_fifo.sv
// Synchronous event FIFO with an occupancy counter; the head reads as zero while empty.
module aer_sync_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             push;
    logic             pop;

    assign empty   = (count == '0);
    assign full    = (count == LVL_W'(DEPTH));
    assign push    = wr_en && (!full || rd_en);
    assign pop     = rd_en && !empty;
    assign level   = count;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/aer_rate_encoder.sv
// Rate-codes a binary pixel pattern into per-pixel spike trains and serialises them as AER events.
module aer_rate_encoder
    import snn_aer_pkg::*;
#(
    parameter int N_PIX         = 4,
    parameter int ADDR_W        = aer_addr_w(N_PIX),
    parameter int PERIOD_W      = 8,
    parameter int ACTIVE_PERIOD = DEF_ACTIVE_PERIOD,
    parameter int QUIET_PERIOD  = DEF_QUIET_PERIOD,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_W         = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic [N_PIX-1:0]                pixel,
    output logic [N_PIX-1:0]                spike_out,
    output logic [ADDR_W-1:0]               aer_addr,
    output logic                            aer_valid,
    input  logic                            aer_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic [CNT_W-1:0]                drop_count
);
    localparam logic [PERIOD_W-1:0] ACTIVE_LAST = PERIOD_W'(ACTIVE_PERIOD - 1);
    localparam logic [PERIOD_W-1:0] QUIET_LAST  = PERIOD_W'(QUIET_PERIOD - 1);
    localparam bit                  QUIET_NEVER = (QUIET_PERIOD == 0);

    function automatic logic [6:0] popcount(input logic [N_PIX-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < N_PIX; i++) n = n + 7'(v[i]);
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [6:0] b);
        logic [CNT_W+7:0] s;
        s = {8'd0, a} + (CNT_W+8)'(b);
        return (|s[CNT_W+7:CNT_W]) ? '1 : s[CNT_W-1:0];
    endfunction

    logic [PERIOD_W-1:0] cnt_p0  [N_PIX];
    logic [PERIOD_W-1:0] cnt_nxt [N_PIX];
    logic [PERIOD_W-1:0] cur;
    logic [PERIOD_W-1:0] last;
    logic [N_PIX-1:0]    pix_prev_p0;
    logic [N_PIX-1:0]    spike_p0;
    logic [N_PIX-1:0]    spike_nxt;

    logic [N_PIX-1:0]    pend_p1;
    logic [N_PIX-1:0]    grant;
    logic [ADDR_W-1:0]   rr_ptr_p1;
    logic [ADDR_W-1:0]   addr_p1;
    logic                vld_p1;
    logic [CNT_W-1:0]    drop_p1;

    logic                fifo_empty;
    logic                fifo_full;
    logic                pop;

    // Stage p0: per-pixel period counters; a pixel change restarts its phase in the same cycle
    always_comb begin
        cur       = '0;
        last      = '0;
        spike_nxt = '0;
        for (int i = 0; i < N_PIX; i++) begin
            cnt_nxt[i] = '0;
            cur  = (pixel[i] != pix_prev_p0[i]) ? '0 : cnt_p0[i];
            last = pixel[i] ? ACTIVE_LAST : QUIET_LAST;
            if (enable && (pixel[i] || !QUIET_NEVER)) begin
                if (cur == last) spike_nxt[i] = 1'b1;
                else             cnt_nxt[i]   = cur + PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_prev_p0 <= '0;
            spike_p0    <= '0;
            for (int i = 0; i < N_PIX; i++) cnt_p0[i] <= '0;
        end else begin
            pix_prev_p0 <= pixel;
            spike_p0    <= spike_nxt;
            for (int i = 0; i < N_PIX; i++) cnt_p0[i] <= cnt_nxt[i];
        end
    end

    assign spike_out = spike_p0;

    // Stage p1: pending bits and round-robin grant into the FIFO
    assign pop       = aer_ready && !fifo_empty;
    assign aer_valid = !fifo_empty;

    always_comb begin
        vld_p1  = 1'b0;
        addr_p1 = '0;
        if (!fifo_full || pop) begin
            for (int k = 0; k < N_PIX; k++) begin
                if (!vld_p1 && pend_p1[(int'(rr_ptr_p1) + k) % N_PIX]) begin
                    vld_p1  = 1'b1;
                    addr_p1 = ADDR_W'((int'(rr_ptr_p1) + k) % N_PIX);
                end
            end
        end
        grant = vld_p1 ? (N_PIX'(1) << addr_p1) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_p1   <= '0;
            rr_ptr_p1 <= '0;
            drop_p1   <= '0;
        end else begin
            pend_p1 <= (pend_p1 & ~grant) | spike_p0;
            drop_p1 <= sat_add(drop_p1, popcount(spike_p0 & pend_p1 & ~grant));
            if (vld_p1)
                rr_ptr_p1 <= (addr_p1 == ADDR_W'(N_PIX - 1)) ? '0 : addr_p1 + ADDR_W'(1);
        end
    end

    assign drop_count = drop_p1;

    aer_sync_fifo #(
        .WIDTH(ADDR_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (vld_p1),
        .wr_data(addr_p1),
        .rd_en  (pop),
        .rd_data(aer_addr),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .level  (fifo_level)
    );

endmodule

// File: tb/tb_aer_rate_encoder.sv
// Scoreboard bench for aer_rate_encoder: time-based spike model, event queue, directed and random phases.
`timescale 1ns/1ps
module tb_aer_rate_encoder;

    localparam int N_PIX         = 4;
    localparam int ADDR_W        = 2;
    localparam int PERIOD_W      = 8;
    localparam int ACTIVE_PERIOD = 5;
    localparam int QUIET_PERIOD  = 0;
    localparam int FIFO_DEPTH    = 4;
    localparam int CNT_W         = 4;
    localparam int LVL_W         = $clog2(FIFO_DEPTH + 1);
    localparam int DROP_MAX      = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic [N_PIX-1:0]   pixel;
    logic [N_PIX-1:0]   spike_out;
    logic [ADDR_W-1:0]  aer_addr;
    logic               aer_valid;
    logic               aer_ready;
    logic [LVL_W-1:0]   fifo_level;
    logic [CNT_W-1:0]   drop_count;

    aer_rate_encoder #(
        .N_PIX(N_PIX), .ADDR_W(ADDR_W), .PERIOD_W(PERIOD_W),
        .ACTIVE_PERIOD(ACTIVE_PERIOD), .QUIET_PERIOD(QUIET_PERIOD),
        .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pixel(pixel),
        .spike_out(spike_out), .aer_addr(aer_addr), .aer_valid(aer_valid),
        .aer_ready(aer_ready), .fifo_level(fifo_level), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    // Reference model state: phase origin per pixel, pending set, queue of expected events
    int               cyc = 0;
    int               t0 [N_PIX];
    logic [N_PIX-1:0] m_spk  = '0;
    logic [N_PIX-1:0] m_pend = '0;
    logic [N_PIX-1:0] m_prev = '0;
    int               m_ptr   = 0;
    int               m_lvl   = 0;
    int               m_drops = 0;
    int               exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int g;
        int per;
        bit pop;
        if (!rst_n) begin
            for (int i = 0; i < N_PIX; i++) t0[i] = cyc + 1;
            m_spk = '0; m_pend = '0; m_prev = '0;
            m_ptr = 0; m_lvl = 0; m_drops = 0;
            exp_q.delete();
        end else begin
            pop = (m_lvl > 0) && (aer_ready === 1'b1);
            g = -1;
            if (m_lvl < FIFO_DEPTH || pop)
                for (int k = 0; k < N_PIX; k++)
                    if (g < 0 && m_pend[(m_ptr + k) % N_PIX]) g = (m_ptr + k) % N_PIX;
            for (int i = 0; i < N_PIX; i++) begin
                if (m_spk[i] && m_pend[i] && i != g && m_drops < DROP_MAX) m_drops++;
                m_pend[i] = (m_pend[i] && i != g) || m_spk[i];
            end
            if (g >= 0) begin
                exp_q.push_back(g);
                m_ptr = (g + 1) % N_PIX;
            end
            m_lvl = m_lvl + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
            for (int i = 0; i < N_PIX; i++) begin
                per = pixel[i] ? ACTIVE_PERIOD : QUIET_PERIOD;
                if (!enable) begin
                    t0[i]    = cyc + 1;
                    m_spk[i] = 1'b0;
                end else begin
                    if (pixel[i] != m_prev[i]) t0[i] = cyc;
                    m_spk[i] = (per != 0) && (((cyc - t0[i] + 1) % per) == 0);
                end
                m_prev[i] = pixel[i];
            end
        end
        cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: compare every cycle, pop the scoreboard on each accepted event
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            check("spike_out", 32'(spike_out), 32'(m_spk));
            check("fifo_level", 32'(fifo_level), 32'(m_lvl));
            check("drop_count", 32'(drop_count), 32'(m_drops));
            check("aer_valid", 32'(aer_valid), 32'(m_lvl > 0));
            if (aer_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL aer_addr: got %0d, want no event (queue empty)", aer_addr);
                end else begin
                    check("aer_addr", 32'(aer_addr), 32'(exp_q[0]));
                    if (aer_ready === 1'b1) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run exceeded time limit, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int got[$];
        rst_n = 1'b0; enable = 1'b0; pixel = '0; aer_ready = 1'b1;
        tick();
        mon_en = 1'b1;
        rst_n  = 1'b1;
        check("rst_valid", 32'(aer_valid), 0);
        check("rst_addr", 32'(aer_addr), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_drops", 32'(drop_count), 0);
        check("rst_spikes", 32'(spike_out), 0);

        // Single active pixel, consumer always ready
        pixel = 4'b0001;
        tick(); tick();
        enable = 1'b1;
        n = 0;
        while (aer_valid !== 1'b1 && n < 30) begin tick(); n++; end
        check("a_first_valid_latency", 32'(n), 7);
        check("a_addr", 32'(aer_addr), 0);
        tick();
        n = 1;
        while (aer_valid !== 1'b1 && n < 30) begin tick(); n++; end
        check("a_event_gap", 32'(n), 5);
        check("a_addr2", 32'(aer_addr), 0);
        repeat (20) tick();
        check("a_drops", 32'(drop_count), 0);

        // All pixels active: four consecutive events per period
        enable = 1'b0; pixel = 4'b1111;
        do_reset();
        tick(); tick();
        enable = 1'b1;
        n = 0;
        while (aer_valid !== 1'b1 && n < 30) begin tick(); n++; end
        check("b_latency", 32'(n), 7);
        for (int p = 0; p < 2; p++) begin
            for (int j = 0; j < 4; j++) begin
                check("b_valid", 32'(aer_valid), 1);
                check("b_addr", 32'(aer_addr), 32'(j));
                tick();
            end
            n = 0;
            while (aer_valid !== 1'b1 && n < 10) begin tick(); n++; end
            check("b_gap", 32'(n), 1);
        end
        check("b_drops", 32'(drop_count), 0);

        // Backpressure: FIFO fills, pending saturates, drops accumulate then saturate
        enable = 1'b0; pixel = 4'b1111; aer_ready = 1'b0;
        do_reset();
        tick(); tick();
        enable = 1'b1;
        repeat (17) tick();
        check("c_drop_period3", 32'(drop_count), 4);
        check("c_level_full", 32'(fifo_level), 4);
        repeat (5) tick();
        check("c_drop_period4", 32'(drop_count), 8);
        check("c_addr_held", 32'(aer_addr), 0);
        repeat (19) tick();
        check("c_level_full_end", 32'(fifo_level), 4);
        check("c_addr_held_end", 32'(aer_addr), 0);
        check("c_valid_held", 32'(aer_valid), 1);
        check("c_drop_saturated", 32'(drop_count), 32'(DROP_MAX));
        aer_ready = 1'b1;
        got.delete();
        n = 0;
        while (got.size() < 8 && n < 40) begin
            if (aer_valid === 1'b1) got.push_back(int'(aer_addr));
            tick();
            n++;
        end
        check("c_drain_count", 32'(got.size()), 8);
        for (int j = 0; j < 8; j++)
            if (j < got.size()) check("c_drain_order", 32'(got[j]), 32'(j % 4));

        // Pixel 2 turns on mid-stream: spike exactly five cycles after the change
        enable = 1'b1; pixel = '0; aer_ready = 1'b1;
        do_reset();
        repeat (7) tick();
        pixel = 4'b0100;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("d_spike2_timing", 32'(spike_out[2]), 32'(k == 5));
        end

        // Reset asserted with three events queued
        pixel = 4'b0111; aer_ready = 1'b0; enable = 1'b1;
        do_reset();
        n = 0;
        while (fifo_level !== 3 && n < 40) begin tick(); n++; end
        check("e_level_before_reset", 32'(fifo_level), 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("e_valid_after_reset", 32'(aer_valid), 0);
        check("e_addr_after_reset", 32'(aer_addr), 0);
        check("e_level_after_reset", 32'(fifo_level), 0);
        check("e_drops_after_reset", 32'(drop_count), 0);
        check("e_spikes_after_reset", 32'(spike_out), 0);

        // Disable with a full FIFO: drains while no new spikes appear
        pixel = 4'b1111;
        n = 0;
        while (fifo_level !== 4 && n < 40) begin tick(); n++; end
        check("f_level_full", 32'(fifo_level), 4);
        enable = 1'b0; aer_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("f_spikes_quiet", 32'(spike_out), 0);
        end
        check("f_level_drained", 32'(fifo_level), 0);
        check("f_valid_drained", 32'(aer_valid), 0);

        // Randomised traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) pixel = N_PIX'($urandom);
            enable    = ($urandom_range(0, 7) != 0);
            aer_ready = ($urandom_range(0, 2) != 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1'b1; enable = 1'b0; aer_ready = 1'b1;
        repeat (12) tick();
        check("g_final_level", 32'(fifo_level), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
